display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Scan scheduler for the 4-digit multiplexed 7-segment display. It replaces the free-running per-clock digit ring with a timed one:
- a prescaled digit slot;
- double-buffered loading of a 16-bit display value, committed only at frame boundaries (no tearing);
- per-slot brightness duty;
- optional leading-zero blanking.

It drives the anode lines and the digit select/nibble that feed the segment decoder.

## Interface
- CLK_DIV, 50000: clock cycles per digit slot; must be a multiple of 16 and at least 16.
- i_Clk  in  1  system clock, rising edge.
- i_Rst  in  1  reset, asynchronous, active-high.
- i_En  in  1  scan enable; low blanks the display and freezes scanning.
- i_Valor  in  16  display value, 4 nibbles; [3:0] = digit 0 (least significant), [15:12] = digit 3.
- i_Load  in  1  single-cycle request to capture i_Valor into the shadow buffer.
- i_Brillo  in  4  brightness; on-time = (i_Brillo+1)/16 of each slot.
- i_Blank_Ceros  in  1  enables leading-zero blanking.
- o_Anodo  out  4  one-hot anode enable, active-high; 0000 = dark.
- o_Sel  out  2  index of the current digit slot.
- o_Digito  out  4  nibble of the active value for the current slot.
- o_Pend  out  1  shadow holds a value not yet committed.
- o_Frame  out  1  one-cycle pulse on the last cycle of slot 3.

## Operation
- Internal state:
  - div counter 0..CLK_DIV-1;
  - slot 0..3;
  - phase 0..15, which advances every CLK_DIV/16 cycles and resets at slot start;
  - active register (16 bits);
  - shadow register (16 bits);
  - brightness latch (4 bits).
- Slot order is 0,1,2,3,0,… One slot lasts CLK_DIV cycles, so one frame lasts 4*CLK_DIV cycles.
- Load:
  - i_Load high: shadow <= i_Valor and o_Pend <= 1.
  - Several loads before a commit: the last one wins.
- Commit happens on the edge where slot 3 wraps to slot 0, and only if o_Pend=1: active <= shadow, o_Pend <= 0.
  - If i_Load is high on that same edge, i_Valor goes straight into active and o_Pend ends at 0.
- Brightness: i_Brillo is latched at each slot start. The anode is on while phase <= latched value. 15 = always on; 0 = first 1/16 of the slot.
- Blanking, with i_Blank_Ceros=1:
  - digit k (k=1..3) is dark when every active nibble from digit 3 down to digit k is zero;
  - digit 0 is never blanked;
  - a blanked slot still occupies its full time, and o_Sel/o_Digito still advance.
- Enable: i_En=0 forces o_Anodo=0000 and holds div, phase, slot and o_Sel. Loads and the o_Pend logic still operate.
  - Commit happens only at a real frame wrap, so a frozen display never commits.
  - When i_En returns, scanning resumes from the held count.
- o_Anodo = (1 << slot) when en & ~blank(slot) & (phase <= brightness latch), otherwise 0000.
- o_Digito = active[4*slot +: 4].

## Timing
- Reset (asynchronous): all outputs 0, o_Anodo=0000, div/slot/phase=0, active=0, shadow=0, brightness latch=0.
- First edge after reset release with i_En=1 starts slot 0:
  - the brightness latch takes i_Brillo;
  - o_Anodo=0001, o_Sel=00, o_Digito=active[3:0].
- All outputs are registered. o_Sel, o_Digito and o_Anodo change on the edge that starts a slot. o_Anodo also falls on the edge where phase exceeds the latched brightness.
- o_Frame is high exactly for the cycle in which slot=3 and div=CLK_DIV-1.
- Commit latency is 1 to 4*CLK_DIV cycles after i_Load, depending on when in the frame the load arrives.
- Reset in mid-frame returns everything to the reset values immediately and discards a pending shadow value.

## Test plan
- Ring and dwell: CLK_DIV=16, i_Brillo=15, i_En=1.
  - o_Sel runs 0,1,2,3,0 with 16 cycles per step;
  - o_Anodo runs 0001,0010,0100,1000;
  - o_Frame pulses once every 64 cycles.
- Double buffer: load 0x1234 mid-slot 1.
  - o_Pend=1 until the slot 3→0 edge;
  - o_Digito keeps showing the old value until that edge, then shows 4,3,2,1 across the next frame.
- Brightness: CLK_DIV=32, i_Brillo=3.
  - o_Anodo is high for 8 of the 32 cycles in each slot;
  - changing i_Brillo mid-slot takes effect only at the next slot.
- Blanking: active=0x0070, i_Blank_Ceros=1.
  - slots 2 and 3 are dark, slots 0 and 1 are lit;
  - with active=0x0000, only slot 0 is lit, showing 0.
- Edge cases:
  - i_Load exactly on the commit edge: the new value is active at once and o_Pend=0;
  - i_En low for 10 cycles: anodes 0000 and o_Sel held, then scanning resumes from the same count;
  - i_Rst asserted mid-frame with o_Pend=1: all outputs 0 immediately and the shadow value is lost.

Source files
------------

// File: rtl/display_scan_controller.sv
// ----------------------------------------------------------------------------
// display_scan_controller
//
// Timed scan scheduler for a 4-digit multiplexed 7-segment display. Each digit
// owns a slot of CLK_DIV clock cycles. Each slot is split into 16 phases that
// implement a brightness duty. A 16-bit display value is double-buffered: loads
// land in a shadow register and are committed to the active register only when
// slot 3 wraps to slot 0, so a frame never shows a mix of two values.
//
// Parameters:
//   CLK_DIV        clock cycles per digit slot (multiple of 16, at least 16)
//
// Ports:
//   i_Clk          system clock, rising edge
//   i_Rst          asynchronous active-high reset
//   i_En           scan enable; low blanks the anodes and freezes the scan
//   i_Valor        display value, [3:0] = digit 0 ... [15:12] = digit 3
//   i_Load         one-cycle request to capture i_Valor into the shadow
//   i_Brillo       brightness, on-time = (i_Brillo+1)/16 of a slot
//   i_Blank_Ceros  enables leading-zero blanking
//   o_Anodo        one-hot anode enable, active-high, 0000 = dark
//   o_Sel          index of the current digit slot
//   o_Digito       active nibble for the current slot
//   o_Pend         shadow holds a value not yet committed
//   o_Frame        pulse on the last cycle of slot 3
// ----------------------------------------------------------------------------
module display_scan_controller #(
   parameter int unsigned CLK_DIV = 50000
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic        i_En,
   input  logic [15:0] i_Valor,
   input  logic        i_Load,
   input  logic [3:0]  i_Brillo,
   input  logic        i_Blank_Ceros,
   output logic [3:0]  o_Anodo,
   output logic [1:0]  o_Sel,
   output logic [3:0]  o_Digito,
   output logic        o_Pend,
   output logic        o_Frame
);

   // Cycles per brightness phase; CLK_DIV is required to be a multiple of 16.
   localparam int unsigned SUB_DIV = CLK_DIV / 16;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned SUB_W   = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic             r_Run;      // set by the first enabled edge after reset
   logic [DIV_W-1:0] r_Div;
   logic [SUB_W-1:0] r_Sub;
   logic [3:0]       r_Phase;
   logic [1:0]       r_Slot;
   logic [15:0]      r_Active;
   logic [15:0]      r_Shadow;
   logic [3:0]       r_Bright;

   logic [3:0]       r_Anodo;
   logic [1:0]       r_Sel;
   logic [3:0]       r_Digito;
   logic             r_Pend;
   logic             r_Frame;

   // -------------------------------------------------------------------------
   // Next-state signals
   // -------------------------------------------------------------------------
   logic             w_Start;
   logic             w_Advance;
   logic             w_Div_Last;
   logic             w_Sub_Last;
   logic             w_Slot_Start;
   logic             w_Wrap;
   logic             w_Commit;

   logic             w_Run_Next;
   logic [DIV_W-1:0] w_Div_Next;
   logic [SUB_W-1:0] w_Sub_Next;
   logic [3:0]       w_Phase_Next;
   logic [1:0]       w_Slot_Next;
   logic [15:0]      w_Active_Next;
   logic [15:0]      w_Shadow_Next;
   logic [3:0]       w_Bright_Next;
   logic             w_Pend_Next;

   logic             w_Blank;
   logic [3:0]       w_Digito_Next;
   logic [3:0]       w_Anodo_Next;
   logic             w_Frame_Next;

   // -------------------------------------------------------------------------
   // Scan counters: div / phase / slot
   // -------------------------------------------------------------------------
   always_comb begin
      w_Start      = i_En & ~r_Run;
      w_Advance    = i_En & r_Run;
      w_Div_Last   = (r_Div == DIV_LAST);
      w_Sub_Last   = (r_Sub == SUB_LAST);
      w_Slot_Start = w_Start | (w_Advance & w_Div_Last);
      w_Wrap       = w_Advance & w_Div_Last & (r_Slot == 2'd3);

      w_Run_Next   = r_Run | i_En;
      w_Div_Next   = r_Div;
      w_Sub_Next   = r_Sub;
      w_Phase_Next = r_Phase;
      w_Slot_Next  = r_Slot;

      if (w_Start) begin
         // First enabled edge opens slot 0 without advancing the count.
         w_Div_Next   = '0;
         w_Sub_Next   = '0;
         w_Phase_Next = 4'd0;
         w_Slot_Next  = 2'd0;
      end else if (w_Advance) begin
         if (w_Div_Last) begin
            w_Div_Next   = '0;
            w_Sub_Next   = '0;
            w_Phase_Next = 4'd0;
            w_Slot_Next  = r_Slot + 2'd1;
         end else begin
            w_Div_Next = r_Div + DIV_W'(1);
            if (w_Sub_Last) begin
               w_Sub_Next   = '0;
               w_Phase_Next = r_Phase + 4'd1;
            end else begin
               w_Sub_Next = r_Sub + SUB_W'(1);
            end
         end
      end

      // Brightness only changes at slot boundaries so a slot's duty is stable.
      w_Bright_Next = w_Slot_Start ? i_Brillo : r_Bright;
   end

   // -------------------------------------------------------------------------
   // Double buffer
   // -------------------------------------------------------------------------
   always_comb begin
      // A load on the wrap edge bypasses the shadow and lands in active directly.
      w_Commit      = w_Wrap & (r_Pend | i_Load);
      w_Shadow_Next = i_Load ? i_Valor : r_Shadow;
      w_Active_Next = r_Active;
      w_Pend_Next   = r_Pend;

      if (w_Commit) begin
         w_Active_Next = i_Load ? i_Valor : r_Shadow;
         w_Pend_Next   = 1'b0;
      end else if (i_Load) begin
         w_Pend_Next = 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Output decode, evaluated on next-state values so outputs can be registered
   // -------------------------------------------------------------------------
   always_comb begin
      w_Digito_Next = w_Active_Next[3:0];
      w_Blank       = 1'b0;
      unique case (w_Slot_Next)
         2'd0: begin
            w_Digito_Next = w_Active_Next[3:0];
            w_Blank       = 1'b0;
         end
         2'd1: begin
            w_Digito_Next = w_Active_Next[7:4];
            w_Blank       = (w_Active_Next[15:4] == 12'd0);
         end
         2'd2: begin
            w_Digito_Next = w_Active_Next[11:8];
            w_Blank       = (w_Active_Next[15:8] == 8'd0);
         end
         2'd3: begin
            w_Digito_Next = w_Active_Next[15:12];
            w_Blank       = (w_Active_Next[15:12] == 4'd0);
         end
         default: begin
            w_Digito_Next = w_Active_Next[3:0];
            w_Blank       = 1'b0;
         end
      endcase
      w_Blank = w_Blank & i_Blank_Ceros;

      w_Anodo_Next = 4'b0000;
      if (i_En && !w_Blank && (w_Phase_Next <= w_Bright_Next)) begin
         w_Anodo_Next = 4'b0001 << w_Slot_Next;
      end

      // Only asserted on an edge that actually advanced into the last cycle,
      // so a scan frozen on that cycle does not hold the pulse high.
      w_Frame_Next = w_Advance & (w_Slot_Next == 2'd3) & (w_Div_Next == DIV_LAST);
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_Run    <= 1'b0;
         r_Div    <= '0;
         r_Sub    <= '0;
         r_Phase  <= 4'd0;
         r_Slot   <= 2'd0;
         r_Active <= 16'd0;
         r_Shadow <= 16'd0;
         r_Bright <= 4'd0;
         r_Anodo  <= 4'b0000;
         r_Sel    <= 2'd0;
         r_Digito <= 4'd0;
         r_Pend   <= 1'b0;
         r_Frame  <= 1'b0;
      end else begin
         r_Run    <= w_Run_Next;
         r_Div    <= w_Div_Next;
         r_Sub    <= w_Sub_Next;
         r_Phase  <= w_Phase_Next;
         r_Slot   <= w_Slot_Next;
         r_Active <= w_Active_Next;
         r_Shadow <= w_Shadow_Next;
         r_Bright <= w_Bright_Next;
         r_Anodo  <= w_Anodo_Next;
         r_Sel    <= w_Slot_Next;
         r_Digito <= w_Digito_Next;
         r_Pend   <= w_Pend_Next;
         r_Frame  <= w_Frame_Next;
      end
   end

   assign o_Anodo  = r_Anodo;
   assign o_Sel    = r_Sel;
   assign o_Digito = r_Digito;
   assign o_Pend   = r_Pend;
   assign o_Frame  = r_Frame;

endmodule

// File: tb/tb_display_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_display_scan_controller
//
// Self-checking bench. A CLK_DIV=16 instance is tracked cycle by cycle by a
// frame-position model feeding an expected-output queue; hand-written
// sequences and a blanking vector table add fixed expectations. A CLK_DIV=32
// instance shares the stimulus and is used for the brightness duty checks.
// ----------------------------------------------------------------------------
module tb_display_scan_controller;

   localparam int unsigned CD    = 16;
   localparam int unsigned CD32  = 32;
   localparam int unsigned FRAME = 4 * CD;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        load;
   logic        blank;
   logic [15:0] valor;
   logic [3:0]  brillo;

   logic [3:0]  anodo,   anodo32;
   logic [1:0]  sel,     sel32;
   logic [3:0]  digito,  digito32;
   logic        pend,    pend32;
   logic        frame,   frame32;

   always #5 clk = ~clk;

   display_scan_controller #(.CLK_DIV(CD)) u_dut (
      .i_Clk         (clk),
      .i_Rst         (rst),
      .i_En          (en),
      .i_Valor       (valor),
      .i_Load        (load),
      .i_Brillo      (brillo),
      .i_Blank_Ceros (blank),
      .o_Anodo       (anodo),
      .o_Sel         (sel),
      .o_Digito      (digito),
      .o_Pend        (pend),
      .o_Frame       (frame)
   );

   display_scan_controller #(.CLK_DIV(CD32)) u_dut32 (
      .i_Clk         (clk),
      .i_Rst         (rst),
      .i_En          (en),
      .i_Valor       (valor),
      .i_Load        (load),
      .i_Brillo      (brillo),
      .i_Blank_Ceros (blank),
      .o_Anodo       (anodo32),
      .o_Sel         (sel32),
      .o_Digito      (digito32),
      .o_Pend        (pend32),
      .o_Frame       (frame32)
   );

   typedef struct packed {
      logic [3:0] anodo;
      logic [1:0] sel;
      logic [3:0] digito;
      logic       pend;
      logic       frame;
   } out_t;

   typedef struct {
      logic [15:0] val;
      logic        blank;
      logic [3:0]  lit;
      logic [3:0]  d0;
   } blank_vec_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   out_t exp_q[$];

   // Model: position within the frame rather than separate counters.
   bit          m_run;
   int          m_pos;
   logic [15:0] m_active;
   logic [15:0] m_shadow;
   logic        m_pend;
   logic [3:0]  m_bright;

   function automatic out_t dut_out();
      out_t o;
      o.anodo  = anodo;
      o.sel    = sel;
      o.digito = digito;
      o.pend   = pend;
      o.frame  = frame;
      return o;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
      end
   endtask

   task automatic model_edge();
      out_t e;
      int   slot;
      int   phase;
      bit   blanked;
      e = '0;
      if (rst) begin
         m_run    = 0;
         m_pos    = 0;
         m_active = 16'h0;
         m_shadow = 16'h0;
         m_pend   = 1'b0;
         m_bright = 4'h0;
      end else begin
         if (m_run && en && m_pos == FRAME - 1 && (m_pend || load)) begin
            m_active = load ? valor : m_shadow;
            m_pend   = 1'b0;
            if (load) m_shadow = valor;
         end else if (load) begin
            m_shadow = valor;
            m_pend   = 1'b1;
         end
         if (en) begin
            if (!m_run) begin
               m_run    = 1;
               m_pos    = 0;
               m_bright = brillo;
            end else begin
               m_pos = (m_pos + 1) % FRAME;
               if (m_pos % CD == 0) m_bright = brillo;
            end
         end
         slot     = m_pos / CD;
         phase    = (m_pos % CD) / (CD / 16);
         blanked  = blank && slot != 0 && ((m_active >> (4 * slot)) == 16'h0);
         e.sel    = slot[1:0];
         e.digito = 4'(m_active >> (4 * slot));
         e.pend   = m_pend;
         e.anodo  = (en && !blanked && phase <= int'(m_bright)) ? 4'(1 << slot) : 4'b0000;
         e.frame  = en && m_pos == FRAME - 1;
      end
      exp_q.push_back(e);
   endtask

   // One clock: predict, clock, sample 1 time unit after the edge, compare.
   task automatic cycle();
      out_t e;
      out_t g;
      model_edge();
      @(posedge clk);
      #1;
      g = dut_out();
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard at %0t: queue empty", $time);
      end else begin
         e = exp_q.pop_front();
         if (g !== e) begin
            n_fail++;
            $display("FAIL scan at %0t: got anodo=%b sel=%0d dig=%h pend=%b frame=%b, expected anodo=%b sel=%0d dig=%h pend=%b frame=%b",
                     $time, g.anodo, g.sel, g.digito, g.pend, g.frame,
                     e.anodo, e.sel, e.digito, e.pend, e.frame);
         end
      end
   endtask

   task automatic wait_frame();
      int k;
      k = 0;
      while (!frame && k < 200) begin
         cycle();
         k++;
      end
      if (!frame) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_frame: got no o_Frame, expected one within 200 cycles");
      end
   endtask

   task automatic wait_pos(input int p);
      int k;
      k = 0;
      while (m_pos != p && k < 200) begin
         cycle();
         k++;
      end
   endtask

   // Waits for the CLK_DIV=32 instance to start a new slot.
   task automatic wait_slot32();
      logic [1:0] prev;
      int         k;
      prev = sel32;
      k    = 0;
      while (sel32 == prev && k < 80) begin
         cycle();
         k++;
      end
      if (sel32 == prev) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_slot32: got sel32 stuck at %0d, expected a change within 80 cycles", prev);
      end
   endtask

   blank_vec_t bvec[7];
   int         n_frames;
   int         n_sel1;
   int         last_frame;
   int         on_cnt;
   logic [3:0] mask;
   logic [3:0] exp_dig[3];

   initial begin
      bvec[0] = '{val: 16'h0070, blank: 1'b1, lit: 4'b0011, d0: 4'h0};
      bvec[1] = '{val: 16'h0000, blank: 1'b1, lit: 4'b0001, d0: 4'h0};
      bvec[2] = '{val: 16'h0070, blank: 1'b0, lit: 4'b1111, d0: 4'h0};
      bvec[3] = '{val: 16'h0F00, blank: 1'b1, lit: 4'b0111, d0: 4'h0};
      bvec[4] = '{val: 16'h8000, blank: 1'b1, lit: 4'b1111, d0: 4'h0};
      bvec[5] = '{val: 16'h1234, blank: 1'b1, lit: 4'b1111, d0: 4'h4};
      bvec[6] = '{val: 16'h0001, blank: 1'b1, lit: 4'b0001, d0: 4'h1};
      exp_dig[0] = 4'h3;
      exp_dig[1] = 4'h2;
      exp_dig[2] = 4'h1;

      rst    = 1'b1;
      en     = 1'b0;
      load   = 1'b0;
      blank  = 1'b0;
      valor  = 16'h0;
      brillo = 4'hF;
      #1;
      check("reset_outputs", 32'(dut_out()), 32'h0);
      check("reset_outputs32", 32'({anodo32, sel32, digito32, pend32, frame32}), 32'h0);
      cycle();
      cycle();

      // Ring and dwell
      rst = 1'b0;
      en  = 1'b1;
      cycle();
      check("start_anodo", 32'(anodo), 32'h1);
      check("start_sel", 32'(sel), 32'h0);
      n_frames   = 0;
      n_sel1     = 0;
      last_frame = 0;
      for (int i = 1; i < 129; i++) begin
         cycle();
         if (sel == 2'd1) n_sel1++;
         if (frame) begin
            n_frames++;
            if (n_frames == 2) check("frame_spacing", 32'(i - last_frame), 32'(FRAME));
            last_frame = i;
         end
      end
      check("frame_count", 32'(n_frames), 32'h2);
      check("sel1_dwell", 32'(n_sel1), 32'(2 * CD));

      // Double buffer: load mid slot 1
      wait_pos(20);
      load  = 1'b1;
      valor = 16'h1234;
      cycle();
      load = 1'b0;
      check("pend_set", 32'(pend), 32'h1);
      check("old_digit", 32'(digito), 32'h0);
      wait_frame();
      check("pend_before_wrap", 32'(pend), 32'h1);
      check("digit_before_wrap", 32'(digito), 32'h0);
      cycle();
      check("pend_after_commit", 32'(pend), 32'h0);
      check("commit_d0", 32'(digito), 32'h4);
      for (int k = 0; k < 3; k++) begin
         repeat (CD) cycle();
         check("commit_dk", 32'(digito), 32'(exp_dig[k]));
      end

      // Load on the commit edge overrides a pending shadow value
      load  = 1'b1;
      valor = 16'h5555;
      cycle();
      load = 1'b0;
      wait_frame();
      load  = 1'b1;
      valor = 16'hABCD;
      cycle();
      load = 1'b0;
      check("edge_load_pend", 32'(pend), 32'h0);
      check("edge_load_d0", 32'(digito), 32'hD);
      repeat (CD) cycle();
      check("edge_load_d1", 32'(digito), 32'hC);

      // Freeze on the last frame cycle with a load: no commit while frozen
      wait_frame();
      en    = 1'b0;
      load  = 1'b1;
      valor = 16'h9999;
      cycle();
      load = 1'b0;
      check("freeze_pend", 32'(pend), 32'h1);
      for (int k = 0; k < 10; k++) begin
         if (k > 0) cycle();
         check("freeze_hold", 32'({anodo, sel, digito}), 32'({4'b0000, 2'd3, 4'hA}));
      end
      en = 1'b1;
      cycle();
      check("resume_commit", 32'({sel, digito, pend}), 32'({2'd0, 4'h9, 1'b0}));

      // Leading-zero blanking vectors
      for (int v = 0; v < 7; v++) begin
         blank = bvec[v].blank;
         load  = 1'b1;
         valor = bvec[v].val;
         cycle();
         load = 1'b0;
         wait_frame();
         cycle();
         check("blank_d0", 32'(digito), 32'(bvec[v].d0));
         mask = anodo;
         repeat (FRAME - 1) begin
            cycle();
            mask = mask | anodo;
         end
         check("blank_mask", 32'(mask), 32'(bvec[v].lit));
      end

      // Brightness on the CLK_DIV=32 instance
      blank  = 1'b0;
      brillo = 4'd3;
      wait_slot32();
      on_cnt = (anodo32 != 4'b0) ? 1 : 0;
      repeat (CD32 - 1) begin
         cycle();
         if (anodo32 != 4'b0) on_cnt++;
      end
      check("duty_3", 32'(on_cnt), 32'd8);
      cycle();
      on_cnt = (anodo32 != 4'b0) ? 1 : 0;
      repeat (9) begin
         cycle();
         if (anodo32 != 4'b0) on_cnt++;
      end
      brillo = 4'd15;
      repeat (CD32 - 10) begin
         cycle();
         if (anodo32 != 4'b0) on_cnt++;
      end
      check("duty_midslot_change", 32'(on_cnt), 32'd8);
      on_cnt = 0;
      repeat (CD32) begin
         cycle();
         if (anodo32 != 4'b0) on_cnt++;
      end
      check("duty_15", 32'(on_cnt), 32'(CD32));

      // Reset mid-frame with a pending value
      load  = 1'b1;
      valor = 16'h7777;
      cycle();
      load = 1'b0;
      check("pre_reset_pend", 32'(pend), 32'h1);
      repeat (3) cycle();
      #2;
      rst = 1'b1;
      #1;
      check("async_reset", 32'(dut_out()), 32'h0);
      check("async_reset32", 32'({anodo32, sel32, digito32, pend32, frame32}), 32'h0);
      cycle();
      rst = 1'b0;
      repeat (140) cycle();
      check("shadow_lost_pend", 32'(pend), 32'h0);
      check("shadow_lost_digit", 32'(digito), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
